// File: rtl/arb_pkg.sv
// Shared state encoding and limits for the round-robin arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_t;

  localparam int ARB_MAX_REQ = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping modulo N_REQ.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   win_id,
  output logic             win_vld
);

  logic [IDW-1:0]   cand_id [N_REQ];
  logic [N_REQ-1:0] cand_hit;

  // Candidate gi is the requester gi positions above ptr; explicit wrap keeps non-power-of-two sizes correct.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [IDW:0] sum;
    assign sum          = {1'b0, ptr} + (IDW+1)'(gi);
    assign cand_id[gi]  = (sum >= (IDW+1)'(N_REQ)) ? IDW'(sum - (IDW+1)'(N_REQ)) : sum[IDW-1:0];
    assign cand_hit[gi] = req[cand_id[gi]];
  end

  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        win_id  = cand_id[i];
        win_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Round-robin ownership arbiter with release / request-drop / hold-timeout exit.
// Define ARB_PREEMPT_STATS_EN to add the preempt_cnt timeout statistics output.
module fsm_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     release_i,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     grant_pending
`ifdef ARB_PREEMPT_STATS_EN
  ,
  output logic [15:0]              preempt_cnt
`endif
);

  localparam int IDW = $clog2(N_REQ);
  localparam int HCW = $clog2(HOLD_MAX) + 1;

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [HCW-1:0]   hold_q, hold_d;

  logic [IDW-1:0]   win_id;
  logic             win_vld;
  logic             owner_req;
  logic             timeout;
  logic             grant_exit;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_id  (win_id),
    .win_vld (win_vld)
  );

  assign owner_req  = req[gnt_id_q];
  assign timeout    = (hold_q == HCW'(HOLD_MAX - 1));
  assign grant_exit = release_i | ~owner_req | timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    case (state_q)
      ARB_IDLE, ARB_TURN: begin
        if (win_vld) begin
          state_d         = ARB_GRANT;
          gnt_d           = '0;
          gnt_d[win_id]   = 1'b1;
          gnt_id_d        = win_id;
          hold_d          = '0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        // All exit causes share one path, so coincident causes advance the pointer once.
        if (grant_exit) begin
          state_d = ARB_TURN;
          gnt_d   = '0;
          ptr_d   = (gnt_id_q == IDW'(N_REQ - 1)) ? '0 : gnt_id_q + IDW'(1);
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy          = (state_q == ARB_GRANT) || (state_q == ARB_TURN);
    grant_pending = (state_q == ARB_IDLE) && (|req);
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;

`ifdef ARB_PREEMPT_STATS_EN
  logic [15:0] preempt_q, preempt_d;

  // Only a pure timeout counts: the owner still wanted the resource and did not release.
  always_comb begin
    preempt_d = preempt_q;
    if ((state_q == ARB_GRANT) && timeout && !release_i && owner_req && (preempt_q != 16'hFFFF))
      preempt_d = preempt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) preempt_q <= '0;
    else          preempt_q <= preempt_d;
  end

  assign preempt_cnt = preempt_q;
`endif

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Directed, table-driven bench for fsm_rr_arbiter (N_REQ=4, HOLD_MAX=8).
module tb_fsm_rr_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic       release_i;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       grant_pending;
`ifdef ARB_PREEMPT_STATS_EN
  logic [15:0] preempt_cnt;
`endif

  fsm_rr_arbiter #(
    .N_REQ    (4),
    .HOLD_MAX (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .release_i     (release_i),
    .gnt           (gnt),
    .gnt_id        (gnt_id),
    .busy          (busy),
    .grant_pending (grant_pending)
`ifdef ARB_PREEMPT_STATS_EN
    ,
    .preempt_cnt   (preempt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        rel;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic        busy;
    logic        pend;
    logic [15:0] pc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic rl, input logic [3:0] g,
                     input logic [1:0] id, input logic b, input logic p, input logic [15:0] pc);
    vec_t v;
    v.req = r; v.rel = rl; v.gnt = g; v.id = id; v.busy = b; v.pend = p; v.pc = pc;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [3:0] r, input logic rl, input logic [3:0] g,
                       input logic [1:0] id, input logic b, input logic p, input logic [15:0] pc);
    for (int k = 0; k < n; k++) add(r, rl, g, id, b, p, pc);
  endtask

  initial begin
    // Round-robin with release on each grant's first cycle: order 0,1,2,3,0.
    add(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 16'd0);
    add(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 16'd0);
    add(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 16'd0);
    add(4'b1111, 1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 16'd0);
    add(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 16'd0);
    add(4'b1111, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 16'd0);
    add(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 16'd0);
    add(4'b1111, 1'b1, 4'b0000, 2'd3, 1'b1, 1'b0, 16'd0);
    add(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 16'd0);
    add(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 16'd0);
    add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 16'd0);
    // Single requester 2, release in cycle 3, then idle; release in idle ignored.
    add_n(3, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 16'd0);
    add(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 16'd0);
    add(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 16'd0);
    add(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 16'd0);
    // Sole requester 1 times out after 8 cycles, one gap, regranted, then drops.
    add_n(8, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 16'd0);
    add(4'b0010, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, 16'd1);
    add(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 16'd1);
    add(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b0, 16'd1);
    add(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 16'd1);
    // Owner 3, late req[0] does not preempt, req[3] drop wraps to 0.
    add(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 16'd1);
    add(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 16'd1);
    add(4'b0001, 1'b0, 4'b0000, 2'd3, 1'b1, 1'b0, 16'd1);
    add(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 16'd1);
    add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0, 16'd1);
    add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 16'd1);
    // Release coincident with timeout: one exit, pointer advances once (next owner 2, not 1).
    add_n(8, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 16'd1);
    add(4'b0110, 1'b1, 4'b0000, 2'd1, 1'b1, 1'b0, 16'd1);
    add(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 16'd1);
    add(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0, 16'd1);
    add(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 16'd1);

    reset_n   = 1'b0;
    req       = 4'b1111;
    release_i = 1'b0;
    #2;
    chk("reset_gnt",    32'(gnt), 32'h0);
    chk("reset_gnt_id", 32'(gnt_id), 32'h0);
    chk("reset_busy",   32'(busy), 32'h0);
    chk("reset_pend",   32'(grant_pending), 32'h1);
`ifdef ARB_PREEMPT_STATS_EN
    chk("reset_pc",     32'(preempt_cnt), 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      req       = vecs[i].req;
      release_i = vecs[i].rel;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_gnt", i),  32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("row%0d_id", i),   32'(gnt_id), 32'(vecs[i].id));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("row%0d_pend", i), 32'(grant_pending), 32'(vecs[i].pend));
`ifdef ARB_PREEMPT_STATS_EN
      chk($sformatf("row%0d_pc", i),   32'(preempt_cnt), 32'(vecs[i].pc));
`endif
      $display("vec %0d req=%b rel=%b gnt=%b id=%0d busy=%b pend=%b",
               i, req, release_i, gnt, gnt_id, busy, grant_pending);
    end

    // Pointer is now 3: 1001 goes to requester 3, then async reset mid-grant.
    release_i = 1'b0;
    req       = 4'b1001;
    @(posedge clk);
    #1;
    chk("pre_reset_gnt", 32'(gnt), 32'b1000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_gnt",  32'(gnt), 32'h0);
    chk("async_reset_busy", 32'(busy), 32'h0);
    chk("async_reset_id",   32'(gnt_id), 32'h0);
    chk("async_reset_pend", 32'(grant_pending), 32'h1);
    $display("async reset: gnt=%b busy=%b id=%0d", gnt, busy, gnt_id);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("idle_pend", 32'(grant_pending), 32'h1);
    @(posedge clk);
    #1;
    chk("post_reset_gnt", 32'(gnt), 32'b0001);
    chk("post_reset_id",  32'(gnt_id), 32'h0);
    chk("post_reset_pend", 32'(grant_pending), 32'h0);
    $display("post reset grant: gnt=%b id=%0d", gnt, gnt_id);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
